// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered long-latency results
// onto the regfile write port. Optional starvation guard: WB_STARVE_GUARD_EN.
module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_we,
  input  logic [4:0]  alu_rw,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic        stall_a,
  output logic        stall_b,
  output logic        stall_w,
  output logic        rf_we,
  output logic [4:0]  rf_rw,
  output logic [31:0] rf_busw,
  output logic [31:0] pending
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          alu_eff;
  logic          push;
  logic          pop;
  logic          alu_win;
  logic          force_fifo;
  logic          iss_set;
  logic [31:0]   pend_nxt;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign lsu_ready = !full;
  assign alu_eff   = alu_we && (alu_rw != 5'd0);
  assign push      = lsu_valid && !full && (lsu_rd != 5'd0);
  assign pop       = !empty && (!alu_eff || force_fifo);
  assign alu_win   = alu_eff && !force_fifo;
  assign head      = mem[rptr];

  assign iss_ready = !pending[iss_rd];
  assign iss_set   = iss_valid && iss_ready && (iss_rd != 5'd0);
  assign stall_a   = pending[ra];
  assign stall_b   = pending[rb];
  assign stall_w   = pending[alu_rw];

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve;

  assign force_fifo = !empty && (starve == SW'(STARVE_LIMIT));
  assign alu_stall  = force_fifo;

  // count consecutive ALU wins over a waiting FIFO head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
    end else if (pop || empty) begin
      starve <= '0;
    end else if (alu_win) begin
      starve <= starve + SW'(1);
    end
  end
`else
  assign force_fifo = 1'b0;
  assign alu_stall  = 1'b0;
`endif

  // result storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{rd: lsu_rd, data: lsu_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // registered regfile write port; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we   <= 1'b0;
      rf_rw   <= 5'd0;
      rf_busw <= 32'd0;
    end else if (alu_win) begin
      rf_we   <= 1'b1;
      rf_rw   <= alu_rw;
      rf_busw <= alu_data;
    end else if (pop) begin
      rf_we   <= 1'b1;
      rf_rw   <= head.rd;
      rf_busw <= head.data;
    end else begin
      rf_we   <= 1'b0;
    end
  end

  // scoreboard next state: clear on pop, then set so set wins
  always_comb begin
    pend_nxt = pending;
    if (pop) pend_nxt[head.rd] = 1'b0;
    if (iss_set) pend_nxt[iss_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 32'd0;
    end else begin
      pending <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios then random traffic
// against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_we;
  logic [4:0]  alu_rw;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        stall_a;
  logic        stall_b;
  logic        stall_w;
  logic        rf_we;
  logic [4:0]  rf_rw;
  logic [31:0] rf_busw;
  logic [31:0] pending;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_we(alu_we), .alu_rw(alu_rw), .alu_data(alu_data),
    .alu_stall(alu_stall),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_ready(lsu_ready),
    .ra(ra), .rb(rb),
    .stall_a(stall_a), .stall_b(stall_b), .stall_w(stall_w),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_busw(rf_busw),
    .pending(pending)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  typedef struct {
    logic        we;
    logic [4:0]  rw;
    logic [31:0] busw;
    logic [31:0] pend;
  } exp_t;

  res_t        mfifo[$];
  exp_t        sb[$];
  logic [31:0] mpend;
  logic        mwe;
  logic [4:0]  mrw;
  logic [31:0] mbusw;
  int          mstarve;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mfifo.delete();
    sb.delete();
    mpend   = 32'd0;
    mwe     = 1'b0;
    mrw     = 5'd0;
    mbusw   = 32'd0;
    mstarve = 0;
  endtask

  task automatic idle_inputs();
    alu_we    = 1'b0;
    alu_rw    = 5'd0;
    alu_data  = 32'd0;
    iss_valid = 1'b0;
    iss_rd    = 5'd0;
    lsu_valid = 1'b0;
    lsu_rd    = 5'd0;
    lsu_data  = 32'd0;
    ra        = 5'd0;
    rb        = 5'd0;
  endtask

  // drive one cycle, check combinational outputs, advance the model
  task automatic cycle(input logic awe, input logic [4:0] arw,
                       input logic [31:0] adata,
                       input logic iv, input logic [4:0] ird,
                       input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ldata,
                       input logic [4:0] a, input logic [4:0] b);
    logic aeff;
    logic rdy;
    logic irdy;
    logic frc;
    logic popped;
    logic was_empty;
    res_t h;
    exp_t e;
    @(negedge clk);
    alu_we = awe; alu_rw = arw; alu_data = adata;
    iss_valid = iss_valid; iss_valid = iv; iss_rd = ird;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldata;
    ra = a; rb = b;
    #1;
    aeff      = awe && (arw != 5'd0);
    rdy       = (mfifo.size() < DEPTH);
    irdy      = !mpend[ird];
    was_empty = (mfifo.size() == 0);
`ifdef WB_STARVE_GUARD_EN
    frc = (mstarve == LIMIT) && !was_empty;
`else
    frc = 1'b0;
`endif
    chk("lsu_ready", lsu_ready, rdy);
    chk("iss_ready", iss_ready, irdy);
    chk("stall_a", stall_a, mpend[a]);
    chk("stall_b", stall_b, mpend[b]);
    chk("stall_w", stall_w, mpend[arw]);
    chk("alu_stall", alu_stall, frc);
    popped = 1'b0;
    if (aeff && !frc) begin
      mwe = 1'b1; mrw = arw; mbusw = adata;
    end else if (!was_empty) begin
      h = mfifo.pop_front();
      mwe = 1'b1; mrw = h.rd; mbusw = h.data;
      mpend[h.rd] = 1'b0;
      popped = 1'b1;
    end else begin
      mwe = 1'b0;
    end
    if (popped || was_empty) mstarve = 0;
    else mstarve = mstarve + 1;
    if (lv && rdy && lrd != 5'd0) mfifo.push_back('{rd: lrd, data: ldata});
    if (iv && irdy && ird != 5'd0) mpend[ird] = 1'b1;
    e.we = mwe; e.rw = mrw; e.busw = mbusw; e.pend = mpend;
    sb.push_back(e);
  endtask

  task automatic idle_cycle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: compare registered outputs after every active edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rf_we", rf_we, e.we);
        chk("rf_rw", rf_rw, e.rw);
        chk("rf_busw", rf_busw, e.busw);
        chk("pending", pending, e.pend);
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    #2;
    chk("reset rf_we", rf_we, 0);
    chk("reset rf_rw", rf_rw, 0);
    chk("reset rf_busw", rf_busw, 0);
    chk("reset pending", pending, 0);
    chk("reset lsu_ready", lsu_ready, 1);
    chk("reset alu_stall", alu_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write x5
    cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    idle_cycle();

    // issue x7, re-issue refused, result returns and clears
    cycle(0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 7, 0, 0, 0, 7, 1);
    cycle(0, 0, 0, 0, 0, 1, 7, 32'hCAFE, 7, 0);
    idle_cycle();
    idle_cycle();

    // FIFO fills behind ALU traffic, third result held, then drains
    cycle(1, 10, 32'hA10, 0, 0, 1, 11, 32'hB11, 0, 0);
    cycle(1, 12, 32'hA12, 0, 0, 1, 13, 32'hB13, 0, 0);
    cycle(1, 14, 32'hA14, 0, 0, 1, 15, 32'hB15, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 15, 32'hB15, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 15, 32'hB15, 0, 0);
    idle_cycle();
    idle_cycle();

    // writes to x0 never reach the port or the FIFO
    cycle(1, 0, 32'hDEAD, 0, 0, 1, 0, 32'hBEEF, 0, 0);
    idle_cycle();

    // async reset with one FIFO entry and pending[7]
    cycle(1, 3, 32'h333, 1, 7, 1, 4, 32'h444, 0, 0);
    @(negedge clk);
    idle_inputs();
    #2;
    chk("pre-reset pending", pending, 32'h80);
    rst_n = 1'b0;
    #1;
    chk("mid reset rf_we", rf_we, 0);
    chk("mid reset pending", pending, 0);
    chk("mid reset lsu_ready", lsu_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
    idle_cycle();

    // pop of x9 coinciding with a new issue of x9
    cycle(0, 0, 0, 0, 0, 1, 9, 32'h999, 0, 0);
    cycle(0, 0, 0, 1, 9, 0, 0, 0, 9, 0);
    idle_cycle();

    // one FIFO entry under continuous ALU traffic
    cycle(1, 1, 32'h100, 0, 0, 1, 20, 32'h2020, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 5'(2 + i), 32'h200 + i, 0, 0, 0, 0, 0, 20, 0);
    end
    idle_cycle();
    idle_cycle();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 15)),
            $urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < 4; i++) idle_cycle();

    @(posedge clk);
    #3;
    chk("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the register file; owns its single write port (we/rw/busw).
- Merges two sources onto that port: single-cycle ALU results and long-latency results (loads, mul/div), which are buffered in a small FIFO.
- Keeps a pending-register scoreboard so decode can stall on RAW/WAW hazards against outstanding long-latency writes.

Parameters:
DEPTH, 2, long-latency result FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive ALU wins before forced FIFO drain (optional feature only)

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
alu_we  in  1  ALU writeback request
alu_rw  in  5  ALU destination register
alu_data  in  32  ALU result
alu_stall  out  1  ALU writeback refused this cycle (optional feature; tied 0 otherwise)
iss_valid  in  1  long-latency op issued this cycle
iss_rd  in  5  its destination register
iss_ready  out  1  issue permitted (iss_rd not already pending)
lsu_valid  in  1  long-latency result valid
lsu_rd  in  5  result destination
lsu_data  in  32  result value
lsu_ready  out  1  FIFO can accept (not full)
ra, rb  in  5  decode source registers
stall_a, stall_b  out  1  pending[ra], pending[rb]
stall_w  out  1  pending[alu_rw] (WAW guard for decode)
rf_we  out  1  to regfile we
rf_rw  out  5  to regfile rw
rf_busw  out  32  to regfile busw
pending  out  32  scoreboard bitmap

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_rw=0, rf_busw=0, pending=0, FIFO empty, starve counter=0. Reset mid-operation discards FIFO contents and pending bits immediately.
- rf_* are registered: a write selected in cycle N appears on rf_* in cycle N+1. It is stable across the negedge, where the regfile commits it.
- Effective ALU request: alu_we && alu_rw!=0. Writes to x0 are dropped and never occupy the port.
- Arbitration each cycle:
  - Effective ALU request wins.
  - Otherwise, if the FIFO is non-empty, pop the head and drive it.
  - Otherwise rf_we=0; rf_rw and rf_busw hold their previous values.
- FIFO:
  - Push when lsu_valid && lsu_ready && lsu_rd!=0. lsu_rd==0 is accepted and discarded.
  - lsu_ready = !full, combinational from count only.
  - Push and pop in the same cycle when full is legal only if the pop occurs; lsu_ready does not look ahead.
  - Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- Scoreboard:
  - Set: pending[iss_rd] set on iss_valid && iss_ready && iss_rd!=0.
  - iss_ready = !pending[iss_rd].
  - Clear: pending[r] cleared in the cycle the FIFO head for r is popped onto the port.
  - Set and clear of the same bit in the same cycle: set wins.
  - pending[0] is always 0.
- stall_a, stall_b and stall_w are combinational from the current pending register.
  - A register becomes readable in the cycle after its pop. The regfile write lands on that cycle's negedge, and regfile reads are combinational, so the value is visible in the second half of that cycle.
- Decode must not issue an ALU write to a pending rd (stall_w). The block does not check this.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- Defined:
  - A counter counts consecutive cycles where the FIFO is non-empty and the ALU wins; it resets to 0 on any FIFO pop or when the FIFO is empty.
  - When count==STARVE_LIMIT, the FIFO head wins that cycle, alu_stall=1 combinationally, and the counter clears.
  - The pipeline must hold its ALU result while alu_stall=1.
- Undefined: no counter; alu_stall tied 0; the ALU always wins.

Test Plan:
- Reset, then ALU write x5=0x1234: alu_we=1, alu_rw=5 in cycle N -> rf_we=1, rf_rw=5, rf_busw=0x1234 in cycle N+1; pending stays 0.
- iss_valid, iss_rd=7 -> pending[7]=1, stall_a=1 when ra=7, iss_ready=0 for a second rd=7. lsu_valid rd=7 data=0xCAFE with no ALU traffic -> FIFO push, pop next cycle, rf_rw=7 the following cycle, pending[7]=0.
- Continuous ALU writes while 2 results arrive -> FIFO full, lsu_ready=0, third result held. ALU idles -> drains in order with 2 consecutive rf writes, lsu_ready returns to 1.
- Same-cycle pop of rd=9 and iss_valid rd=9 -> pending[9] remains 1.
- ALU write to x0 and lsu result to x0 -> no rf_we and no FIFO occupancy. rst_n low while FIFO holds 1 entry and pending=0x80 -> both cleared asynchronously.
- With WB_STARVE_GUARD_EN and STARVE_LIMIT=4: FIFO holds 1 entry, ALU writes every cycle -> 5th cycle alu_stall=1 and the FIFO entry is written. Without the macro -> no write until the ALU idles.
